// File: rtl/bnn_layer_sched_if.sv
// Weight-fetch and conv_top data-path handshake bundle for bnn_layer_sched.
// The master modport is the scheduler; the slave modport is the weight SRAM / conv_top side.
interface bnn_layer_sched_if #(
    parameter int WT_AW = 8
);
    logic             wt_req;
    logic [WT_AW-1:0] wt_addr;
    logic             wt_ack;
    logic             weight_ready;
    logic             src_valid;
    logic             src_ready;
    logic             conv_valid;
    logic             conv_ready;
    logic             fc_valid;
    logic             fc_ready;
    logic             out_conv_valid;
    logic             out_fc_valid;

    modport master (
        output wt_req, wt_addr, weight_ready, src_ready, conv_valid, fc_valid,
        input  wt_ack, src_valid, conv_ready, fc_ready, out_conv_valid, out_fc_valid
    );

    modport slave (
        input  wt_req, wt_addr, weight_ready, src_ready, conv_valid, fc_valid,
        output wt_ack, src_valid, conv_ready, fc_ready, out_conv_valid, out_fc_valid
    );
endinterface

// File: rtl/bnn_layer_sched.sv
// Sequences the shared conv_top datapath between a conv requester and an fc requester:
// fetches/applies weights, gates the input stream and waits for every result before done.
module bnn_layer_sched #(
    parameter int CONV_PIX     = 81,
    parameter int FC_GROUPS    = 10,
    parameter int MAX_OUT      = 8,
    parameter int WT_AW        = 8,
    parameter int CONV_WT_BASE = 0,
    parameter int FC_WT_BASE   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_conv_i,
    input  logic               start_fc_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               job_is_fc_o,
    output logic               err_o,
    bnn_layer_sched_if.master  bus
);

    localparam int BEAT_W = $clog2(CONV_PIX + 1);
    localparam int GRP_W  = $clog2(FC_GROUPS + 1);
    localparam int OUT_W  = $clog2(MAX_OUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WFETCH,
        WAPPLY,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic               job_fc_q, job_fc_d;
    logic               pend_conv_q, pend_conv_d;
    logic               pend_fc_q, pend_fc_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [GRP_W-1:0]   group_q, group_d;
    logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               err_q, err_d;
    logic [WT_AW-1:0]   wt_addr_q, wt_addr_d;

    logic gate;
    logic port_ready;
    logic accept;
    logic result;

    // Input gating: only in RUN, and only while the in-flight window has room.
    assign gate       = (state_q == RUN) && bus.src_valid && (out_cnt_q < OUT_W'(MAX_OUT));
    assign port_ready = job_fc_q ? bus.fc_ready : bus.conv_ready;
    assign accept     = gate && port_ready;
    assign result     = bus.out_conv_valid || bus.out_fc_valid;

    always_comb begin
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        if (result && (out_cnt_q == '0)) begin
            err_d = 1'b1;
            if (accept) begin
                out_cnt_d = out_cnt_q + OUT_W'(1);
            end
        end else if (accept && !result) begin
            out_cnt_d = out_cnt_q + OUT_W'(1);
        end else if (!accept && result) begin
            out_cnt_d = out_cnt_q - OUT_W'(1);
        end
    end

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        job_fc_d    = job_fc_q;
        pend_conv_d = pend_conv_q || start_conv_i;
        pend_fc_d   = pend_fc_q || start_fc_i;
        beat_cnt_d  = beat_cnt_q;
        group_d     = group_q;
        wt_addr_d   = wt_addr_q;

        unique case (state_q)
            IDLE: begin
                if (pend_conv_d) begin
                    state_d     = WFETCH;
                    job_fc_d    = 1'b0;
                    pend_conv_d = 1'b0;
                    beat_cnt_d  = '0;
                    wt_addr_d   = WT_AW'(CONV_WT_BASE);
                end else if (pend_fc_d) begin
                    state_d   = WFETCH;
                    job_fc_d  = 1'b1;
                    pend_fc_d = 1'b0;
                    group_d   = '0;
                    wt_addr_d = WT_AW'(FC_WT_BASE);
                end
            end
            WFETCH: begin
                if (bus.wt_ack) begin
                    state_d = WAPPLY;
                end
            end
            WAPPLY: begin
                state_d = RUN;
            end
            RUN: begin
                if (accept) begin
                    if (!job_fc_q) begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        if (beat_cnt_q == BEAT_W'(CONV_PIX - 1)) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        group_d = group_q + GRP_W'(1);
                        if (group_q == GRP_W'(FC_GROUPS - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            state_d   = WFETCH;
                            wt_addr_d = WT_AW'(FC_WT_BASE) + WT_AW'(group_q) + WT_AW'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (out_cnt_q == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                job_fc_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            job_fc_q    <= 1'b0;
            pend_conv_q <= 1'b0;
            pend_fc_q   <= 1'b0;
            beat_cnt_q  <= '0;
            group_q     <= '0;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
            wt_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            job_fc_q    <= job_fc_d;
            pend_conv_q <= pend_conv_d;
            pend_fc_q   <= pend_fc_d;
            beat_cnt_q  <= beat_cnt_d;
            group_q     <= group_d;
            out_cnt_q   <= out_cnt_d;
            err_q       <= err_d;
            wt_addr_q   <= wt_addr_d;
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == FIN);
    assign job_is_fc_o      = job_fc_q;
    assign err_o            = err_q;
    assign bus.wt_req       = (state_q == WFETCH);
    assign bus.wt_addr      = wt_addr_q;
    assign bus.weight_ready = (state_q == WAPPLY);
    assign bus.conv_valid   = gate && !job_fc_q;
    assign bus.fc_valid     = gate && job_fc_q;
    assign bus.src_ready    = accept;

    a_wr_single_pulse : assert property (@(posedge clk) disable iff (rst)
        bus.weight_ready |=> !bus.weight_ready);
    a_valid_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(bus.conv_valid && bus.fc_valid));
    a_out_bounded     : assert property (@(posedge clk) disable iff (rst)
        out_cnt_q <= OUT_W'(MAX_OUT));
    a_addr_stable     : assert property (@(posedge clk) disable iff (rst)
        (bus.wt_req && !bus.wt_ack) |=> (bus.wt_req && $stable(bus.wt_addr)));

endmodule

// File: tb/tb_bnn_layer_sched.sv
// Scoreboard bench for bnn_layer_sched: directed jobs push expected weight/done events,
// a monitor pops them as the DUT produces weight_ready and done pulses.
module tb_bnn_layer_sched;

    typedef enum int {EV_WAPPLY = 1, EV_DONE = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       addr;
        int       is_fc;
        int       beats;
    } ev_t;

    logic clk;
    logic rst;
    logic start_conv;
    logic start_fc;
    logic busy;
    logic done;
    logic job_is_fc;
    logic err;

    bnn_layer_sched_if #(.WT_AW(8)) bus ();

    logic ret_conv;
    logic ret_fc;
    logic spur_conv;
    int   ack_delay;
    int   req_age;
    logic req_seen;
    logic auto_ret;
    int   rel_cnt;

    int   n_checks = 0;
    int   n_fails  = 0;
    ev_t  exp_q[$];

    assign bus.out_conv_valid = ret_conv | spur_conv;
    assign bus.out_fc_valid   = ret_fc;
    assign bus.wt_ack         = bus.wt_req && (req_age >= ack_delay);

    bnn_layer_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start_conv_i (start_conv),
        .start_fc_i   (start_fc),
        .busy_o       (busy),
        .done_o       (done),
        .job_is_fc_o  (job_is_fc),
        .err_o        (err),
        .bus          (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: got an event, expected none queued (t=%0t)", name, $time);
    endtask

    task automatic push_conv();
        exp_q.push_back('{kind: EV_WAPPLY, addr: 0, is_fc: 0, beats: 0});
        exp_q.push_back('{kind: EV_DONE, addr: 0, is_fc: 0, beats: 81});
    endtask

    task automatic push_fc();
        for (int g = 0; g < 10; g++) begin
            exp_q.push_back('{kind: EV_WAPPLY, addr: 16 + g, is_fc: 1, beats: 0});
        end
        exp_q.push_back('{kind: EV_DONE, addr: 0, is_fc: 1, beats: 10});
    endtask

    task automatic start(input logic c, input logic f);
        @(posedge clk);
        #1;
        start_conv = c;
        start_fc   = f;
        @(posedge clk);
        #1;
        start_conv = 1'b0;
        start_fc   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    task automatic wait_done(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    // Returns at the negedge on which the n-th conv beat is presented for acceptance.
    task automatic wait_beats(input string name, input int n, input int budget);
        int k;
        k = 0;
        for (int i = 0; i < budget && k < n; i++) begin
            @(negedge clk);
            if (bus.src_ready && bus.conv_valid) k++;
        end
        check(name, k, n);
    endtask

    task automatic count_acc(input int cycles, output int acc);
        acc = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.src_ready && (bus.conv_valid || bus.fc_valid)) acc++;
        end
    endtask

    // Weight SRAM model: ack after ack_delay cycles of an asserted request.
    initial begin
        req_seen = 1'b0;
        req_age  = 0;
        forever begin
            @(negedge clk);
            req_seen = bus.wt_req;
            @(posedge clk);
            #1;
            if (req_seen && bus.wt_req) req_age++;
            else req_age = 0;
        end
    end

    // conv_top result model: one result per accepted beat, one cycle later unless withheld.
    initial begin
        int   owed_c;
        int   owed_f;
        logic acc_c;
        logic acc_f;
        owed_c   = 0;
        owed_f   = 0;
        ret_conv = 1'b0;
        ret_fc   = 1'b0;
        forever begin
            @(negedge clk);
            acc_c = !rst && bus.src_ready && bus.conv_valid;
            acc_f = !rst && bus.src_ready && bus.fc_valid;
            if (acc_c) owed_c++;
            if (acc_f) owed_f++;
            @(posedge clk);
            #2;
            ret_conv = 1'b0;
            ret_fc   = 1'b0;
            if (rst) begin
                owed_c = 0;
                owed_f = 0;
            end else begin
                if (owed_c > 0 && (auto_ret || rel_cnt > 0)) begin
                    ret_conv = 1'b1;
                    owed_c--;
                    if (!auto_ret) rel_cnt--;
                end
                if (owed_f > 0 && (auto_ret || rel_cnt > 0)) begin
                    ret_fc = 1'b1;
                    owed_f--;
                    if (!auto_ret) rel_cnt--;
                end
            end
        end
    end

    // Monitor: pops expected events when the DUT shows weight_ready or done.
    initial begin
        int   beats_c;
        int   beats_f;
        logic wa_seen;
        ev_t  e;
        beats_c = 0;
        beats_f = 0;
        wa_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beats_c = 0;
                beats_f = 0;
                wa_seen = 1'b0;
            end else begin
                if (bus.conv_valid || bus.fc_valid) begin
                    check("valid_exclusive", bus.conv_valid && bus.fc_valid, 1'b0);
                    check("valid_outside_run", bus.wt_req || bus.weight_ready, 1'b0);
                end
                if (bus.weight_ready) begin
                    if (exp_q.size() == 0) begin
                        unexpected("sb_weight_ready");
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_wr_kind", bus.weight_ready ? EV_WAPPLY : EV_DONE, e.kind);
                        check("sb_wr_addr", bus.wt_addr, e.addr);
                        check("sb_wr_is_fc", job_is_fc, e.is_fc);
                    end
                    wa_seen = 1'b1;
                end
                if (bus.src_ready && bus.fc_valid) begin
                    check("fc_one_beat_per_set", wa_seen, 1'b1);
                    wa_seen = 1'b0;
                    beats_f++;
                end
                if (bus.src_ready && bus.conv_valid) beats_c++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        unexpected("sb_done");
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_done_kind", done ? EV_DONE : EV_WAPPLY, e.kind);
                        check("sb_done_is_fc", job_is_fc, e.is_fc);
                        check("sb_done_beats", e.is_fc != 0 ? beats_f : beats_c, e.beats);
                        check("sb_done_other_port", e.is_fc != 0 ? beats_c : beats_f, 0);
                    end
                    beats_c = 0;
                    beats_f = 0;
                end
            end
        end
    end

    initial begin
        int acc;
        rst            = 1'b1;
        start_conv     = 1'b0;
        start_fc       = 1'b0;
        spur_conv      = 1'b0;
        auto_ret       = 1'b1;
        rel_cnt        = 0;
        ack_delay      = 2;
        bus.src_valid  = 1'b1;
        bus.conv_ready = 1'b1;
        bus.fc_ready   = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_job_is_fc", job_is_fc, 1'b0);
        check("rst_wt_req", bus.wt_req, 1'b0);
        check("rst_wt_addr", bus.wt_addr, 0);
        check("rst_weight_ready", bus.weight_ready, 1'b0);
        check("rst_src_ready", bus.src_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Conv job, weight ack two cycles into the request.
        push_conv();
        start(1'b1, 1'b0);
        wait_idle("conv_job_complete", 300);
        check("conv_err", err, 1'b0);
        check("conv_job_is_fc_after", job_is_fc, 1'b0);

        // FC job, immediate weight ack.
        ack_delay = 0;
        push_fc();
        start(1'b0, 1'b1);
        wait_idle("fc_job_complete", 200);
        check("fc_err", err, 1'b0);

        // Simultaneous starts: conv first, fc right after; a repeat fc start is absorbed.
        ack_delay = 1;
        push_conv();
        push_fc();
        start(1'b1, 1'b1);
        repeat (5) @(posedge clk);
        start(1'b0, 1'b1);
        wait_done("arb_conv_done", 300);
        @(negedge clk);
        check("arb_idle_gap_busy", busy, 1'b0);
        check("arb_idle_gap_wt_req", bus.wt_req, 1'b0);
        @(negedge clk);
        check("arb_fc_fetch", bus.wt_req, 1'b1);
        check("arb_fc_type", job_is_fc, 1'b1);
        wait_idle("arb_fc_complete", 300);
        repeat (20) @(negedge clk);
        check("arb_no_extra_job", busy, 1'b0);

        // Backpressure: results withheld, window of 8, then one release, then steady state.
        auto_ret = 1'b0;
        push_conv();
        start(1'b1, 1'b0);
        wait_beats("bp_first_window", 8, 100);
        count_acc(3, acc);
        check("bp_throttled_beats", acc, 0);
        check("bp_conv_valid_low", bus.conv_valid, 1'b0);
        check("bp_src_ready_low", bus.src_ready, 1'b0);
        @(posedge clk);
        #1;
        rel_cnt = 1;
        count_acc(4, acc);
        check("bp_one_more_beat", acc, 1);
        check("bp_rethrottled", bus.conv_valid, 1'b0);
        @(posedge clk);
        #1;
        auto_ret = 1'b1;
        count_acc(3, acc);
        count_acc(10, acc);
        check("bp_steady_rate", acc, 10);
        wait_idle("bp_job_complete", 300);
        check("bp_err", err, 1'b0);

        // Spurious result while idle: sticky err, no state change, cleared by rst.
        @(posedge clk);
        #1;
        spur_conv = 1'b1;
        @(posedge clk);
        #1;
        spur_conv = 1'b0;
        @(negedge clk);
        check("spur_err_set", err, 1'b1);
        check("spur_busy", busy, 1'b0);
        check("spur_wt_req", bus.wt_req, 1'b0);
        repeat (5) @(negedge clk);
        check("spur_err_sticky", err, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("spur_err_cleared", err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset in the middle of a conv run, then a clean full job.
        exp_q.push_back('{kind: EV_WAPPLY, addr: 0, is_fc: 0, beats: 0});
        start(1'b1, 1'b0);
        wait_beats("midrun_reach_40", 40, 200);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_busy", busy, 1'b0);
        check("midrun_conv_valid", bus.conv_valid, 1'b0);
        check("midrun_src_ready", bus.src_ready, 1'b0);
        check("midrun_wt_req", bus.wt_req, 1'b0);
        check("midrun_done", done, 1'b0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_conv();
        start(1'b1, 1'b0);
        wait_idle("post_rst_job_complete", 300);
        check("post_rst_err", err, 1'b0);

        check("sb_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
